// File: rtl/conv_job_sequencer_if.sv
// Row-command channel between the job sequencer and the conv datapath.
`timescale 1ns/1ps
interface conv_job_sequencer_if #(
    parameter int ADDR_W = 32
) ();
    logic              cmd_valid_o;
    logic              cmd_ready_i;
    logic [7:0]        cmd_filter_o;
    logic [7:0]        cmd_row_o;
    logic [ADDR_W-1:0] cmd_rd_addr_o;
    logic [ADDR_W-1:0] cmd_wr_addr_o;
    logic [7:0]        cmd_len_o;
    logic              row_done_i;

    modport master (
        output cmd_valid_o, cmd_filter_o, cmd_row_o, cmd_rd_addr_o, cmd_wr_addr_o, cmd_len_o,
        input  cmd_ready_i, row_done_i
    );

    modport slave (
        input  cmd_valid_o, cmd_filter_o, cmd_row_o, cmd_rd_addr_o, cmd_wr_addr_o, cmd_len_o,
        output cmd_ready_i, row_done_i
    );
endinterface

// File: rtl/conv_job_sequencer.sv
// Sequences one convolution job: latches config on a begin edge, validates it,
// then issues one row command per output row per filter under a credit limit.
`timescale 1ns/1ps
module conv_job_sequencer #(
    parameter int KERNEL          = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [ADDR_W-1:0] out_addr_i,
    input  logic              begin_conv_i,
    input  logic [7:0]        height_i,
    input  logic [7:0]        width_i,
    input  logic [7:0]        num_filters_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    conv_job_sequencer_if.master cmd
);
    localparam logic [7:0] K8    = 8'(KERNEL);
    localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              begin_prev_q, begin_prev_d;
    // Set once begin has been seen low since reset, so a level held through reset cannot start a job.
    logic              seen_low_q, seen_low_d;
    logic [ADDR_W-1:0] in_base_q, in_base_d;
    logic [ADDR_W-1:0] out_base_q, out_base_d;
    logic [7:0]        h_q, h_d, w_q, w_d, f_q, f_d, len_q, len_d;
    logic [7:0]        filter_q, filter_d, row_q, row_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [3:0]        credit_q, credit_d;
    logic              err_q, err_d;
    logic              valid, hs, dec;

    // Next-state, command-field and credit computation.
    always_comb begin
        state_d      = state_q;
        begin_prev_d = begin_conv_i;
        seen_low_d   = seen_low_q | ~begin_conv_i;
        in_base_d    = in_base_q;
        out_base_d   = out_base_q;
        h_d          = h_q;
        w_d          = w_q;
        f_d          = f_q;
        len_d        = len_q;
        filter_d     = filter_q;
        row_d        = row_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        credit_d     = credit_q;
        err_d        = err_q;

        valid = (state_q == S_ISSUE) && (credit_q < MAX_C);
        hs    = valid && cmd.cmd_ready_i;
        dec   = cmd.row_done_i && (credit_q != 4'd0);

        if (hs && !dec) begin
            credit_d = credit_q + 4'd1;
        end else if (!hs && dec) begin
            credit_d = credit_q - 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (begin_conv_i && !begin_prev_q && seen_low_q) begin
                    state_d    = S_CHECK;
                    in_base_d  = in_addr_i;
                    out_base_d = out_addr_i;
                    h_d        = height_i;
                    w_d        = width_i;
                    f_d        = num_filters_i;
                    len_d      = width_i - K8 + 8'd1;
                    err_d      = 1'b0;
                end
            end
            S_CHECK: begin
                if (h_q < K8 || w_q < K8 || f_q == 8'd0) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d   = S_ISSUE;
                    filter_d  = '0;
                    row_d     = '0;
                    rd_addr_d = in_base_q;
                    wr_addr_d = out_base_q;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(len_q);
                    if (row_q == h_q - K8) begin
                        // Next filter re-reads the image from the top; output planes stay contiguous.
                        row_d     = '0;
                        filter_d  = filter_q + 8'd1;
                        rd_addr_d = in_base_q;
                        if (filter_q == f_q - 8'd1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        row_d     = row_q + 8'd1;
                        rd_addr_d = rd_addr_q + ADDR_W'(w_q);
                    end
                end
            end
            S_DRAIN: begin
                if (credit_q == 4'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            begin_prev_q <= 1'b0;
            seen_low_q   <= 1'b0;
            in_base_q    <= '0;
            out_base_q   <= '0;
            h_q          <= '0;
            w_q          <= '0;
            f_q          <= '0;
            len_q        <= '0;
            filter_q     <= '0;
            row_q        <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            credit_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            begin_prev_q <= begin_prev_d;
            seen_low_q   <= seen_low_d;
            in_base_q    <= in_base_d;
            out_base_q   <= out_base_d;
            h_q          <= h_d;
            w_q          <= w_d;
            f_q          <= f_d;
            len_q        <= len_d;
            filter_q     <= filter_d;
            row_q        <= row_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            credit_q     <= credit_d;
            err_q        <= err_d;
        end
    end

    assign cmd.cmd_valid_o   = valid;
    assign cmd.cmd_filter_o  = filter_q;
    assign cmd.cmd_row_o     = row_q;
    assign cmd.cmd_rd_addr_o = rd_addr_q;
    assign cmd.cmd_wr_addr_o = wr_addr_q;
    assign cmd.cmd_len_o     = len_q;
    assign busy_o = (state_q == S_CHECK) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_o = (state_q == S_DONE);
    assign err_o  = err_q;
endmodule

// File: tb/tb_conv_job_sequencer.sv
// Directed bench for conv_job_sequencer with hand-computed expected commands.
`timescale 1ns/1ps
module tb_conv_job_sequencer;
    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] in_addr_i, out_addr_i;
    logic        begin_conv_i;
    logic [7:0]  height_i, width_i, num_filters_i;
    logic        busy_o, done_o, err_o;

    conv_job_sequencer_if #(.ADDR_W(32)) cif ();

    conv_job_sequencer #(.KERNEL(3), .MAX_OUTSTANDING(2), .ADDR_W(32)) dut (
        .clk(clk), .rst_i(rst_i), .in_addr_i(in_addr_i), .out_addr_i(out_addr_i),
        .begin_conv_i(begin_conv_i), .height_i(height_i), .width_i(width_i),
        .num_filters_i(num_filters_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .cmd(cif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       ready_v = 1'b0, auto_rd = 1'b0, man_rd = 1'b0;
    logic [1:0] pipe = '0;
    logic       last_hs = 1'b0;
    int         done_cnt = 0, busy_cnt = 0;
    logic [7:0]  q_f[$], q_r[$], q_l[$];
    logic [31:0] q_rd[$], q_wr[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive handshake inputs at the falling edge and record accepted commands.
    task automatic tick();
        logic hs;
        @(negedge clk);
        pipe = {pipe[0], last_hs};
        cif.row_done_i  = man_rd | (auto_rd & pipe[1]);
        cif.cmd_ready_i = ready_v;
        hs = cif.cmd_valid_o & ready_v;
        if (hs) begin
            q_f.push_back(cif.cmd_filter_o);
            q_r.push_back(cif.cmd_row_o);
            q_l.push_back(cif.cmd_len_o);
            q_rd.push_back(cif.cmd_rd_addr_o);
            q_wr.push_back(cif.cmd_wr_addr_o);
        end
        if (done_o) done_cnt++;
        if (busy_o) busy_cnt++;
        last_hs = hs;
    endtask

    task automatic clr();
        q_f.delete(); q_r.delete(); q_l.delete(); q_rd.delete(); q_wr.delete();
        done_cnt = 0; busy_cnt = 0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'(1));
    endtask

    task automatic start_job(input logic [31:0] ia, input logic [31:0] oa,
                             input logic [7:0] h, input logic [7:0] w, input logic [7:0] f);
        begin_conv_i = 1'b0;
        tick();
        in_addr_i = ia; out_addr_i = oa; height_i = h; width_i = w; num_filters_i = f;
        clr();
        begin_conv_i = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(cif.cmd_valid_o), 64'(0));
        chk({tag, "_busy"},  64'(busy_o), 64'(0));
        chk({tag, "_done"},  64'(done_o), 64'(0));
        chk({tag, "_err"},   64'(err_o), 64'(0));
        chk({tag, "_filter"}, 64'(cif.cmd_filter_o), 64'(0));
        chk({tag, "_row"},    64'(cif.cmd_row_o), 64'(0));
        chk({tag, "_rd"},     64'(cif.cmd_rd_addr_o), 64'(0));
        chk({tag, "_wr"},     64'(cif.cmd_wr_addr_o), 64'(0));
        chk({tag, "_len"},    64'(cif.cmd_len_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_f[6]  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
        logic [7:0]  exp_r[6]  = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        logic [31:0] exp_rd[6] = '{32'h1000, 32'h1006, 32'h100C, 32'h1000, 32'h1006, 32'h100C};
        logic [31:0] exp_wr[6] = '{32'h8000, 32'h8004, 32'h8008, 32'h800C, 32'h8010, 32'h8014};
        logic [7:0]  s_f, s_r, s_l;
        logic [31:0] s_rd, s_wr;

        rst_i = 1'b1; begin_conv_i = 1'b0;
        in_addr_i = '0; out_addr_i = '0; height_i = '0; width_i = '0; num_filters_i = '0;
        cif.cmd_ready_i = 1'b0; cif.row_done_i = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        repeat (2) tick();

        // Basic job, begin left high afterwards.
        auto_rd = 1'b1; ready_v = 1'b1;
        start_job(32'h1000, 32'h8000, 8'd5, 8'd6, 8'd2);
        chk("basic_busy_check", 64'(busy_o), 64'(1));
        chk("basic_err_check", 64'(err_o), 64'(0));
        run_until_done("basic", 200);
        chk("basic_err_at_done", 64'(err_o), 64'(0));
        chk("basic_ncmd", 64'(q_f.size()), 64'(6));
        if (q_f.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("basic_filter%0d", i), 64'(q_f[i]), 64'(exp_f[i]));
                chk($sformatf("basic_row%0d", i), 64'(q_r[i]), 64'(exp_r[i]));
                chk($sformatf("basic_rd%0d", i), 64'(q_rd[i]), 64'(exp_rd[i]));
                chk($sformatf("basic_wr%0d", i), 64'(q_wr[i]), 64'(exp_wr[i]));
                chk($sformatf("basic_len%0d", i), 64'(q_l[i]), 64'(4));
            end
        end
        busy_cnt = 0;
        repeat (10) tick();
        chk("basic_single_done", 64'(done_cnt), 64'(1));
        chk("held_begin_no_restart", 64'(busy_cnt), 64'(0));

        // Credit limit, backpressure and simultaneous events on a fresh job.
        auto_rd = 1'b0; ready_v = 1'b1;
        start_job(32'h1000, 32'h8000, 8'd5, 8'd6, 8'd2);
        chk("toggle_restart_busy", 64'(busy_o), 64'(1));
        repeat (20) tick();
        chk("credit_two_hs", 64'(q_f.size()), 64'(2));
        chk("credit_valid_low", 64'(cif.cmd_valid_o), 64'(0));

        ready_v = 1'b0; man_rd = 1'b1;
        tick();
        man_rd = 1'b0;
        tick();
        tick();
        chk("bp_valid_up", 64'(cif.cmd_valid_o), 64'(1));
        s_f = cif.cmd_filter_o; s_r = cif.cmd_row_o; s_l = cif.cmd_len_o;
        s_rd = cif.cmd_rd_addr_o; s_wr = cif.cmd_wr_addr_o;
        chk("bp_row", 64'(s_r), 64'(2));
        chk("bp_rd", 64'(s_rd), 64'(32'h100C));
        chk("bp_wr", 64'(s_wr), 64'(32'h8008));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", i), 64'(cif.cmd_valid_o), 64'(1));
            chk($sformatf("bp_hold_fields%0d", i),
                64'({cif.cmd_filter_o, cif.cmd_row_o, cif.cmd_len_o} == {s_f, s_r, s_l} &&
                    cif.cmd_rd_addr_o == s_rd && cif.cmd_wr_addr_o == s_wr), 64'(1));
        end
        ready_v = 1'b1;
        repeat (10) tick();
        chk("credit_one_more", 64'(q_f.size()), 64'(3));
        chk("credit_valid_low2", 64'(cif.cmd_valid_o), 64'(0));
        if (q_r.size() >= 3) chk("bp_no_skip_row", 64'(q_r[2]), 64'(2));

        ready_v = 1'b0; man_rd = 1'b1;
        tick();
        man_rd = 1'b0;
        tick();
        tick();
        chk("sim_pre_valid", 64'(cif.cmd_valid_o), 64'(1));
        ready_v = 1'b1; man_rd = 1'b1;
        tick();
        ready_v = 1'b0; man_rd = 1'b0;
        tick();
        tick();
        chk("sim_credit_unchanged", 64'(cif.cmd_valid_o), 64'(1));
        ready_v = 1'b1;
        tick();
        ready_v = 1'b0;
        tick();
        tick();
        chk("sim_credit_full", 64'(cif.cmd_valid_o), 64'(0));
        chk("sim_ncmd", 64'(q_f.size()), 64'(5));
        if (q_f.size() == 5) begin
            chk("sim_cmd4_filter", 64'(q_f[3]), 64'(1));
            chk("sim_cmd4_wr", 64'(q_wr[3]), 64'(32'h800C));
            chk("sim_cmd5_rd", 64'(q_rd[4]), 64'(32'h1006));
        end

        // Reset mid-ISSUE with begin held high.
        rst_i = 1'b1;
        tick();
        tick();
        chk_all_zero("midrst");
        rst_i = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        repeat (10) tick();
        chk("midrst_no_done", 64'(done_cnt), 64'(0));
        chk("midrst_no_restart", 64'(busy_cnt), 64'(0));

        // Bad configurations.
        auto_rd = 1'b1; ready_v = 1'b1;
        start_job(32'h2000, 32'h9000, 8'd2, 8'd6, 8'd2);
        chk("bad_h_busy_check", 64'(busy_o), 64'(1));
        run_until_done("bad_h", 20);
        chk("bad_h_err", 64'(err_o), 64'(1));
        chk("bad_h_ncmd", 64'(q_f.size()), 64'(0));
        start_job(32'h2000, 32'h9000, 8'd5, 8'd6, 8'd0);
        run_until_done("bad_f", 20);
        chk("bad_f_err", 64'(err_o), 64'(1));
        chk("bad_f_ncmd", 64'(q_f.size()), 64'(0));
        start_job(32'h3000, 32'hA000, 8'd3, 8'd3, 8'd1);
        chk("good_err_cleared", 64'(err_o), 64'(0));
        run_until_done("good_small", 50);
        chk("good_small_ncmd", 64'(q_f.size()), 64'(1));
        if (q_f.size() == 1) begin
            chk("good_small_len", 64'(q_l[0]), 64'(1));
            chk("good_small_rd", 64'(q_rd[0]), 64'(32'h3000));
            chk("good_small_wr", 64'(q_wr[0]), 64'(32'hA000));
        end
        chk("good_small_err", 64'(err_o), 64'(0));

        // Address wrap.
        start_job(32'hFFFF_FFFC, 32'h0, 8'd4, 8'd8, 8'd1);
        run_until_done("wrap", 50);
        chk("wrap_ncmd", 64'(q_f.size()), 64'(2));
        if (q_f.size() == 2) begin
            chk("wrap_rd0", 64'(q_rd[0]), 64'(32'hFFFF_FFFC));
            chk("wrap_rd1", 64'(q_rd[1]), 64'(32'h0000_0004));
            chk("wrap_wr1", 64'(q_wr[1]), 64'(32'h6));
            chk("wrap_row1", 64'(q_r[1]), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_job_sequencer.md
Name: conv_job_sequencer

Overview:
- Sequences one convolution job for the U-Net conv engine from the AXI-Lite configuration registers: input/output base address, image height/width, filter count, begin flag.
- On a begin edge it latches the configuration, then issues one command per output row per filter to the conv datapath over a valid/ready handshake.
- Bounds in-flight rows with a credit counter and reports busy/done/error back to the register block.

Parameters:
- KERNEL, 3, square kernel size; output rows = H-KERNEL+1, output row length = W-KERNEL+1.
- MAX_OUTSTANDING, 2, maximum issued-but-not-completed row commands (1..15).
- ADDR_W, 32, address width.

Ports:
- clk  input  1  clock
- rst_i  input  1  synchronous active-high reset
- in_addr_i  input  ADDR_W  input image base address (InputImageAddress)
- out_addr_i  input  ADDR_W  output image base address (OutputImageAddress)
- begin_conv_i  input  1  level from config register (BeginConv); only its rising edge starts a job
- height_i  input  8  image height in pixels
- width_i  input  8  image width in pixels
- num_filters_i  input  8  filter count
- cmd_valid_o  output  1  row command valid
- cmd_ready_i  input  1  datapath accepts command
- cmd_filter_o  output  8  filter index
- cmd_row_o  output  8  output row index
- cmd_rd_addr_o  output  ADDR_W  address of first of KERNEL input rows
- cmd_wr_addr_o  output  ADDR_W  output row address
- cmd_len_o  output  8  output row length W-KERNEL+1
- row_done_i  input  1  one-cycle pulse per completed row
- busy_o  output  1  job in progress
- done_o  output  1  one-cycle pulse at job end (including error end)
- err_o  output  1  sticky; bad config on last job

Behaviour:
- Reset: state IDLE; all outputs 0; the begin_conv_i edge register is cleared to 0. A begin level held through reset does not start a job until it drops and rises again.
- Reset mid-job: abandons the job immediately and does not assert done_o. Any credits are dropped.
- Start: in IDLE, begin_conv_i=1 with its previous-cycle value 0 moves to CHECK next cycle. All inputs are latched on that cycle, and err_o clears. Edges while not in IDLE are ignored.
- CHECK, 1 cycle:
  - If height<KERNEL, width<KERNEL or num_filters==0: go to DONE and set err_o.
  - Otherwise go to ISSUE with filter=0, row=0, rd_addr=in_base, wr_addr=out_base.
- ISSUE:
  - cmd_valid_o=1 while outstanding<MAX_OUTSTANDING. Command fields are registered and stable while valid && !ready.
  - On handshake:
    - rd_addr += width.
    - wr_addr += W-KERNEL+1.
    - row++.
    - When row==H-KERNEL: row=0, filter++, rd_addr=in_base. wr_addr keeps accumulating, so output planes are contiguous.
  - After the handshake for the last filter's last row, go to DRAIN. cmd_valid_o drops the next cycle.
  - cmd_valid_o must not drop without a handshake except on reset.
- Credit counter:
  - +1 on handshake, -1 on row_done_i; simultaneous handshake and row_done_i leaves it unchanged.
  - row_done_i at outstanding==0 is ignored (no underflow).
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE, 1 cycle: done_o=1, busy_o=0, return to IDLE.
- busy_o=1 in CHECK, ISSUE and DRAIN.
- Arithmetic:
  - Addresses are unsigned ADDR_W and wrap modulo 2^ADDR_W.
  - Address updates use incremental adders only; no multipliers.
  - cmd_len_o = W-KERNEL+1, 8 bits.

Test Plan:
- Basic job: in=0x1000, out=0x8000, H=5, W=6, F=2; ready=1; row_done_i 2 cycles after each accept.
  - Response: 6 commands. Rows 0,1,2 per filter. rd_addr 0x1000, 0x1006, 0x100C, repeated for each filter. wr_addr 0x8000, 0x8004 … 0x8014. len=4. Single done_o, err_o=0.
- Credit limit: MAX_OUTSTANDING=2, no row_done_i.
  - Response: exactly 2 handshakes, then cmd_valid_o=0. One row_done_i → exactly one more command.
- Backpressure: cmd_ready_i low 5 cycles with valid high → all cmd_* fields stable; no skipped or duplicated rows.
- Bad config: H=2 or F=0 → CHECK, then done_o pulse, err_o=1, zero commands. Next valid start clears err_o.
- Begin held high across job end → no restart. Toggle 0→1 → new job.
- Simultaneous events and reset:
  - Handshake and row_done_i in the same cycle → credit count unchanged.
  - rst_i mid-ISSUE → next cycle all outputs 0, no done_o.
- Address wrap: in=0xFFFFFFFC, W=8 → second rd_addr=0x00000004.
